// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package fetch_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_SLOT_SIZE  = 200;
    localparam int DEF_NUM_SLOTS  = 4;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // Fixed roles of the low ROM slots; every slot from SLOT_PROG0 up holds a user program.
    typedef enum logic [1:0] {
        SLOT_CTX   = 2'd0,
        SLOT_OS    = 2'd1,
        SLOT_PROG0 = 2'd2
    } slot_idx_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: control inputs, ROM port and the decode-side instruction stream.
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = fetch_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = fetch_pkg::DEF_ADDR_WIDTH,
    parameter int NUM_SLOTS  = fetch_pkg::DEF_NUM_SLOTS
) ();

    logic                         stall;
    logic                         branch_valid;
    logic [ADDR_WIDTH-1:0]        branch_target;
    logic                         ctx_valid;
    logic [$clog2(NUM_SLOTS)-1:0] ctx_slot;
    logic [ADDR_WIDTH-1:0]        rom_addr;
    logic [DATA_WIDTH-1:0]        rom_q;
    logic [DATA_WIDTH-1:0]        instr;
    logic                         instr_valid;
    logic [ADDR_WIDTH-1:0]        instr_pc;
    logic [$clog2(NUM_SLOTS)-1:0] cur_slot;
    logic                         fault;

    // Fetch unit side.
    modport master (
        input  stall, branch_valid, branch_target, ctx_valid, ctx_slot, rom_q,
        output rom_addr, instr, instr_valid, instr_pc, cur_slot, fault
    );

    // Environment side: decode, branch/context control and the ROM.
    modport slave (
        output stall, branch_valid, branch_target, ctx_valid, ctx_slot, rom_q,
        input  rom_addr, instr, instr_valid, instr_pc, cur_slot, fault
    );

endinterface

// File: rtl/instr_fetch_unit_slot_pc_table.sv
// Saved program counter per ROM slot; one synchronous write, one combinational read.
module slot_pc_table #(
    parameter int ADDR_WIDTH = 32,
    parameter int SLOT_SIZE  = 200,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(NUM_SLOTS)-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0]        wdata,
    input  logic [$clog2(NUM_SLOTS)-1:0] raddr,
    output logic [ADDR_WIDTH-1:0]        rdata
);

    logic [ADDR_WIDTH-1:0] saved_pc [NUM_SLOTS];

    // Each slot starts at its own base address; writes record a resume point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                saved_pc[i] <= ADDR_WIDTH'(i * SLOT_SIZE);
            end
        end else if (we) begin
            saved_pc[waddr] <= wdata;
        end
    end

    assign rdata = saved_pc[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the 1-cycle-latency ROM, streams words to decode,
// handles branches, per-slot context switching and out-of-slot fault detection.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SLOT_SIZE  = DEF_SLOT_SIZE,
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS
) (
    input logic              clk,
    input logic              rst_n,
    instr_fetch_unit_if.master bus
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic [SLOT_W-1:0]     cur_slot;
    logic                  fault;
    logic                  primed;

    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] limit;
    logic [ADDR_WIDTH-1:0] resume_pc;
    logic [ADDR_WIDTH-1:0] saved_rd;
    logic                  ctx_bad;
    logic                  tbl_we;

    function automatic logic in_slot(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] lo,
                                     input logic [ADDR_WIDTH-1:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    assign base  = ADDR_WIDTH'(cur_slot) * ADDR_WIDTH'(SLOT_SIZE);
    assign limit = base + ADDR_WIDTH'(SLOT_SIZE - 1);

    // The word on display has not been consumed yet, so it is where the slot resumes.
    assign resume_pc = instr_valid ? instr_pc : fetch_pc;

    // A power-of-two slot count leaves no unused slot encodings to reject.
    if (NUM_SLOTS == (1 << SLOT_W)) begin : g_slot_full
        assign ctx_bad = 1'b0;
    end else begin : g_slot_partial
        assign ctx_bad = (32'(bus.ctx_slot) >= 32'(NUM_SLOTS));
    end

    assign tbl_we = bus.ctx_valid && !ctx_bad;

    slot_pc_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLOT_SIZE  (SLOT_SIZE),
        .NUM_SLOTS  (NUM_SLOTS)
    ) u_slot_pc_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cur_slot),
        .wdata (resume_pc),
        .raddr (bus.ctx_slot),
        .rdata (saved_rd)
    );

    // Fetch FSM: context switch beats branch beats stall beats sequential fetch.
    // The first cycle out of reset only issues word 0 and captures nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            fetch_pc    <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            cur_slot    <= SLOT_W'(SLOT_CTX);
            fault       <= 1'b0;
            primed      <= 1'b0;
        end else if (bus.ctx_valid) begin
            instr_valid <= 1'b0;
            primed      <= 1'b1;
            if (ctx_bad) begin
                fault <= 1'b1;
                state <= FAULT;
            end else begin
                cur_slot <= bus.ctx_slot;
                // Same-slot switch: the table write lands this edge, so forward it.
                fetch_pc <= (bus.ctx_slot == cur_slot) ? resume_pc : saved_rd;
                fault    <= 1'b0;
                state    <= FETCH;
            end
        end else if (state == FAULT) begin
            instr_valid <= 1'b0;
            fault       <= 1'b1;
        end else if (bus.branch_valid) begin
            instr_valid <= 1'b0;
            primed      <= 1'b1;
            if (in_slot(bus.branch_target, base, limit)) begin
                fetch_pc <= bus.branch_target;
            end else begin
                fault <= 1'b1;
                state <= FAULT;
            end
        end else if (!primed) begin
            primed <= 1'b1;
        end else if (bus.stall && instr_valid) begin
            instr_valid <= 1'b1;
        end else if (!in_slot(fetch_pc, base, limit)) begin
            instr_valid <= 1'b0;
            fault       <= 1'b1;
            state       <= FAULT;
        end else begin
            instr_pc    <= fetch_pc;
            instr_valid <= 1'b1;
            fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
        end
    end

    // Re-reading the held word during a stall keeps rom_q stable.
    assign bus.rom_addr    = (bus.stall && instr_valid) ? instr_pc : fetch_pc;
    assign bus.instr       = bus.rom_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_pc    = instr_pc;
    assign bus.cur_slot    = cur_slot;
    assign bus.fault       = fault;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the synchronous instruction ROM interface. Drives the ROM address and consumes the 1-cycle-latency read data.
- Presents a valid/stall instruction stream to decode.
- Handles branches and per-slot context switching. ROM is partitioned into fixed slots: slot 0 = context-switch routine, slot 1 = OS, slots 2..N-1 = user programs.
- Keeps a saved PC per slot and faults on any fetch outside the active slot.

Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, ROM address width
- SLOT_SIZE, 200, words per program slot
- NUM_SLOTS, 4, number of slots (NUM_SLOTS*SLOT_SIZE = ROM depth, 800)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  decode not ready; hold the current instruction
- branch_valid  in  1  redirect request
- branch_target  in  ADDR_WIDTH  absolute branch address
- ctx_valid  in  1  context switch request
- ctx_slot  in  $clog2(NUM_SLOTS)  destination slot
- rom_addr  out  ADDR_WIDTH  address to ROM (ROM registers data on posedge clk)
- rom_q  in  DATA_WIDTH  ROM read data, 1 cycle after address
- instr  out  DATA_WIDTH  instruction to decode (= rom_q)
- instr_valid  out  1  instr/instr_pc valid
- instr_pc  out  ADDR_WIDTH  address of instr
- cur_slot  out  $clog2(NUM_SLOTS)  active slot
- fault  out  1  out-of-slot fetch detected; sticky

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=0, cur_slot=0, instr_valid=0, instr_pc=0, fault=0.
  - saved_pc[i]=i*SLOT_SIZE for all i. State FETCH.
  - Reset mid-operation discards in-flight data. instr_valid is 0 the cycle after reset releases; the first valid is word 0 two cycles after release.
- States: FETCH, FAULT.
- Address mux: rom_addr = (stall && instr_valid) ? instr_pc : fetch_pc. During a stall this re-reads the held word, so rom_q stays stable.
- Slot bounds: base = cur_slot*SLOT_SIZE, limit = base+SLOT_SIZE-1. Arithmetic is unsigned and ADDR_WIDTH wide.
- Priority per cycle: reset > ctx_valid > branch_valid > stall > sequential.
- Sequential step (FETCH, no stall): instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+1.
  - If fetch_pc > limit: no increment, instr_valid<=0, fault<=1, go to FAULT.
  - There is no wrap into the neighbouring slot.
- Stall (instr_valid=1): fetch_pc, instr_pc and instr_valid are held.
  - stall with instr_valid=0 is ignored; fetch proceeds.
- Branch:
  - fetch_pc<=branch_target, instr_valid<=0. This is a one-cycle bubble; the in-flight word is discarded.
  - A target outside [base,limit] sets fault and enters FAULT.
  - Branch wins over stall.
- Context switch:
  - saved_pc[cur_slot]<=resume point: instr_pc if instr_valid, else fetch_pc. The next unexecuted instruction is preserved.
  - cur_slot<=ctx_slot, fetch_pc<=saved_pc[ctx_slot], instr_valid<=0, fault<=0, state FETCH.
  - ctx_slot >= NUM_SLOTS sets fault and enters FAULT; cur_slot is unchanged.
  - ctx_valid with branch_valid: ctx wins and the branch is dropped.
  - Valid from FAULT as well; this is the only exit besides reset.
- FAULT: instr_valid=0, rom_addr held, fault=1, stall and branch ignored.
- Latency: address to instr_valid is 1 cycle. Steady state delivers 1 instr/cycle.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_state_t {FETCH, FAULT}
  - localparams SLOT_SIZE/NUM_SLOTS defaults
  - slot-index enum: SLOT_CTX=0, SLOT_OS=1, SLOT_PROG0=2
- Sub-module slot_pc_table: NUM_SLOTS x ADDR_WIDTH saved-PC register file. One synchronous write port, one combinational read port, reset to slot bases.

Test Plan:
- Reset then run with the ROM model; no stall -> instr_pc 0,1,2,3 on consecutive cycles; instr_valid first high 2 cycles after rst_n rises.
- Stall high for 3 cycles while instr_pc=5 -> instr_pc=5 and instr=rom[5] held all 3 cycles; instr_pc=6 the cycle after stall drops.
- branch_valid with target 150 while at pc 10 -> one cycle instr_valid=0, then instr_pc=150,151.
- At slot 2 pc 420, ctx_valid slot 1 -> cur_slot=1, fetch resumes at 200. Then ctx_valid slot 2 -> resumes at 420, no duplicated or skipped word.
- In slot 3, run sequentially to 799 -> instr_pc=799 delivered, then fault=1 and instr_valid=0. A branch is ignored. ctx_valid slot 1 -> fault=0, fetch at 200.
- branch to 250 while in slot 0 -> fault=1. Assert rst_n=0 one cycle mid-stream -> all outputs at reset values, restart at 0.
